// File: rtl/uart_tx_fifo_cfg.sv
// UART transmitter with a valid/ready input FIFO and per-frame configuration:
// baud divisor, parity (none/even/odd) and 1 or 2 stop bits.
module uart_tx_fifo_cfg #(
   parameter int unsigned DW         = 8,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned DIV_W      = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          tx_valid_i,
   input  logic [DW-1:0]                 tx_data_i,
   output logic                          tx_ready_o,
   input  logic [DIV_W-1:0]              baud_div_i,
   input  logic [1:0]                    parity_i,
   input  logic                          stop2_i,
   output logic                          tx_o,
   output logic                          tx_busy_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;
   localparam int unsigned BIT_W = $clog2(DW);

   localparam logic [4:0] S_IDLE   = 5'b00001;
   localparam logic [4:0] S_START  = 5'b00010;
   localparam logic [4:0] S_DATA   = 5'b00100;
   localparam logic [4:0] S_PARITY = 5'b01000;
   localparam logic [4:0] S_STOP   = 5'b10000;

   logic [4:0]       state_q, state_d;
   logic [DW-1:0]    mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             ready_q, ready_d;
   logic [DIV_W-1:0] div_q, div_d, cnt_q, cnt_d;
   logic [DW-1:0]    shift_q, shift_d;
   logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic             par_en_q, par_en_d, par_bit_q, par_bit_d;
   logic             stop2_q, stop2_d, stop_cnt_q, stop_cnt_d;
   logic             tx_q, tx_d, busy_q, busy_d;
   logic             push, launch, tick, fifo_empty, final_stop;
   logic [DIV_W-1:0] div_clamped;
   logic [DW-1:0]    head;

   assign fifo_empty  = (level_q == '0);
   assign push        = tx_valid_i & ready_q;
   assign tick        = (cnt_q == div_q - DIV_W'(1));
   assign final_stop  = ~stop2_q | stop_cnt_q;
   assign div_clamped = (baud_div_i < DIV_W'(2)) ? DIV_W'(2) : baud_div_i;
   assign head        = mem_q[rd_ptr_q];
   // A frame launches from IDLE or straight out of the last stop bit (zero gap)
   assign launch      = ~fifo_empty &
                        ((state_q == S_IDLE) | ((state_q == S_STOP) & tick & final_stop));

   always_comb begin
      state_d    = state_q;
      cnt_d      = tick ? '0 : cnt_q + DIV_W'(1);
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      div_d      = div_q;
      par_en_d   = par_en_q;
      par_bit_d  = par_bit_q;
      stop2_d    = stop2_q;
      stop_cnt_d = stop_cnt_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;

      case (state_q)
         S_IDLE: cnt_d = '0;
         S_START: begin
            if (tick) begin
               state_d   = S_DATA;
               bit_cnt_d = '0;
            end
         end
         S_DATA: begin
            if (tick) begin
               if (bit_cnt_q == BIT_W'(DW - 1)) begin
                  state_d = par_en_q ? S_PARITY : S_STOP;
               end else begin
                  shift_d   = shift_q >> 1;
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
               end
            end
         end
         S_PARITY: if (tick) state_d = S_STOP;
         S_STOP: begin
            if (tick) begin
               if (final_stop) state_d = S_IDLE;
               else            stop_cnt_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Frame registers are latched only here, so mid-frame config changes wait
      if (launch) begin
         state_d    = S_START;
         cnt_d      = '0;
         shift_d    = head;
         div_d      = div_clamped;
         par_en_d   = ^parity_i;
         par_bit_d  = (^head) ^ (parity_i == 2'b10);
         stop2_d    = stop2_i;
         stop_cnt_d = 1'b0;
         rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      end

      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (push && !launch)      level_d = level_q + LVL_W'(1);
      else if (!push && launch) level_d = level_q - LVL_W'(1);
      ready_d = (level_d != LVL_W'(FIFO_DEPTH));

      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[0];
         S_PARITY: tx_d = par_bit_d;
         default:  tx_d = 1'b1;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         ready_q    <= 1'b1;
         div_q      <= DIV_W'(2);
         cnt_q      <= '0;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         par_en_q   <= 1'b0;
         par_bit_q  <= 1'b0;
         stop2_q    <= 1'b0;
         stop_cnt_q <= 1'b0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         ready_q    <= ready_d;
         div_q      <= div_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         par_en_q   <= par_en_d;
         par_bit_q  <= par_bit_d;
         stop2_q    <= stop2_d;
         stop_cnt_q <= stop_cnt_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= tx_data_i;
   end

   assign tx_o         = tx_q;
   assign tx_busy_o    = busy_q;
   assign tx_ready_o   = ready_q;
   assign fifo_level_o = level_q;
endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// Bench for uart_tx_fifo_cfg: a per-cycle waveform model checked on every
// negedge plus hand-computed frame bit patterns for the directed cases.
module tb_uart_tx_fifo_cfg;
   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned DIV_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             tx_valid;
   logic [DW-1:0]    tx_data;
   logic             tx_ready_o;
   logic [DIV_W-1:0] baud;
   logic [1:0]       parity;
   logic             stop2;
   logic             tx_o;
   logic             tx_busy_o;
   logic [$clog2(DEPTH):0] fifo_level_o;

   int n_cmp = 0;
   int n_err = 0;
   bit check_en = 1'b0;

   uart_tx_fifo_cfg #(.DW(DW), .FIFO_DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
      .clk_i(clk), .rst_i(rst), .tx_valid_i(tx_valid), .tx_data_i(tx_data),
      .tx_ready_o(tx_ready_o), .baud_div_i(baud), .parity_i(parity),
      .stop2_i(stop2), .tx_o(tx_o), .tx_busy_o(tx_busy_o),
      .fifo_level_o(fifo_level_o)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: queued words plus the remaining per-cycle line levels of the current frame
   logic [DW-1:0] mq[$];
   bit            wave[$];
   bit            exp_tx = 1'b1, exp_busy = 1'b0, exp_ready = 1'b1;
   int            exp_level = 0;

   always @(posedge clk) begin
      bit            do_push;
      logic [DW-1:0] w;
      int            d;
      bit            pbit;
      if (rst) begin
         mq.delete();
         wave.delete();
      end else begin
         do_push = tx_valid && (mq.size() < DEPTH);
         if (wave.size() > 0) void'(wave.pop_front());
         if (wave.size() == 0 && mq.size() > 0) begin
            w    = mq.pop_front();
            d    = (baud < 2) ? 2 : int'(baud);
            pbit = (^w) ^ (parity == 2'b10);
            for (int k = 0; k < d; k++) wave.push_back(1'b0);
            for (int i = 0; i < DW; i++)
               for (int k = 0; k < d; k++) wave.push_back(w[i]);
            if (parity == 2'b01 || parity == 2'b10)
               for (int k = 0; k < d; k++) wave.push_back(pbit);
            for (int k = 0; k < d * (stop2 ? 2 : 1); k++) wave.push_back(1'b1);
         end
         if (do_push) mq.push_back(tx_data);
      end
      exp_tx    = (wave.size() > 0) ? wave[0] : 1'b1;
      exp_busy  = (wave.size() > 0);
      exp_level = mq.size();
      exp_ready = (mq.size() < DEPTH);
   end

   always @(negedge clk) begin
      if (check_en) begin
         check("model_tx_o", 32'(tx_o), 32'(exp_tx));
         check("model_tx_busy_o", 32'(tx_busy_o), 32'(exp_busy));
         check("model_fifo_level_o", 32'(fifo_level_o), 32'(exp_level));
         check("model_tx_ready_o", 32'(tx_ready_o), 32'(exp_ready));
      end
   end

   // Called at posedge+1; the push lands on the returning edge
   task automatic push_word(input logic [DW-1:0] d);
      int n = 0;
      tx_valid = 1'b1;
      tx_data  = d;
      @(negedge clk);
      while (tx_ready_o !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("push_ready_wait", 32'(tx_ready_o), 32'd1);
      @(posedge clk); #1;
      tx_valid = 1'b0;
   endtask

   task automatic wait_tx_low(input string name);
      int n = 0;
      @(negedge clk);
      while (tx_o !== 1'b0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check({name, "_start_wait"}, 32'(tx_o), 32'd0);
   endtask

   // bits[0] is the first bit on the line; leaves off at the negedge after the frame
   task automatic check_frame(input string name, input logic [15:0] bits, input int nbits,
                              input int d, input bit started, input bit idle_after);
      int busy_n = 0;
      if (!started) wait_tx_low(name);
      for (int c = 0; c < nbits * d; c++) begin
         if ((c % d == 0) || (c % d == d - 1))
            check($sformatf("%s_bit%0d", name, c / d), 32'(tx_o), 32'(bits[c / d]));
         busy_n += int'(tx_busy_o);
         @(negedge clk);
      end
      check({name, "_busy_cycles"}, 32'(busy_n), 32'(nbits * d));
      check({name, "_after_tx"}, 32'(tx_o), idle_after ? 32'd1 : 32'd0);
      check({name, "_after_busy"}, 32'(tx_busy_o), idle_after ? 32'd0 : 32'd1);
   endtask

   initial begin
      int n;
      int lows;
      rst = 1'b1; tx_valid = 1'b0; tx_data = '0;
      baud = 16'd4; parity = 2'b00; stop2 = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check_en = 1'b1;
      @(negedge clk);
      check("reset_tx", 32'(tx_o), 32'd1);
      check("reset_busy", 32'(tx_busy_o), 32'd0);
      check("reset_level", 32'(fifo_level_o), 32'd0);
      check("reset_ready", 32'(tx_ready_o), 32'd1);

      // 8N1, D=4, 0xA5
      @(posedge clk); #1;
      push_word(8'hA5);
      check_frame("t1_a5", 16'h034A, 10, 4, 1'b0, 1'b1);

      // Even then odd parity on 0x07
      @(posedge clk); #1; parity = 2'b01;
      push_word(8'h07);
      check_frame("t2_even", 16'h060E, 11, 4, 1'b0, 1'b1);
      @(posedge clk); #1; parity = 2'b10;
      push_word(8'h07);
      check_frame("t2_odd", 16'h040E, 11, 4, 1'b0, 1'b1);

      // Two stop bits, back-to-back frames with no gap
      @(posedge clk); #1; parity = 2'b00; stop2 = 1'b1;
      push_word(8'h00);
      push_word(8'hFF);
      check_frame("t3_w1", 16'h0600, 11, 4, 1'b0, 1'b0);
      check_frame("t3_w2", 16'h07FE, 11, 4, 1'b1, 1'b1);

      // Valid held high while the line is busy: FIFO fills, then refills after a pop
      @(posedge clk); #1; stop2 = 1'b0; tx_data = 8'h3C; tx_valid = 1'b1;
      repeat (6) @(negedge clk);
      check("t4_level_full", 32'(fifo_level_o), 32'd4);
      check("t4_ready_full", 32'(tx_ready_o), 32'd0);
      n = 0;
      while (tx_ready_o !== 1'b1 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("t4_ready_rise", 32'(tx_ready_o), 32'd1);
      check("t4_level_after_pop", 32'(fifo_level_o), 32'd3);
      @(posedge clk); #1; tx_valid = 1'b0;
      @(negedge clk);
      check("t4_level_refill", 32'(fifo_level_o), 32'd4);
      check("t4_ready_refill", 32'(tx_ready_o), 32'd0);
      n = 0;
      while ((tx_busy_o !== 1'b0 || fifo_level_o !== '0) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("t4_drained", 32'(tx_busy_o), 32'd0);

      // Divisor below 2 clamps to 2
      @(posedge clk); #1; baud = 16'd1;
      push_word(8'h5A);
      check_frame("t5_div1", 16'h02B4, 10, 2, 1'b0, 1'b1);

      // Divisor change after launch affects only the next frame
      @(posedge clk); #1; baud = 16'd4;
      push_word(8'hA5);
      push_word(8'h0F);
      baud = 16'd8;
      check_frame("t5_div4", 16'h034A, 10, 4, 1'b0, 1'b0);
      check_frame("t5_div8", 16'h021E, 10, 8, 1'b1, 1'b1);

      // Reset during DATA with two words queued
      @(posedge clk); #1; baud = 16'd4;
      push_word(8'h81);
      push_word(8'h42);
      push_word(8'h24);
      repeat (8) @(negedge clk);
      check("t6_pre_level", 32'(fifo_level_o), 32'd2);
      check("t6_pre_busy", 32'(tx_busy_o), 32'd1);
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      check("t6_tx", 32'(tx_o), 32'd1);
      check("t6_busy", 32'(tx_busy_o), 32'd0);
      check("t6_level", 32'(fifo_level_o), 32'd0);
      check("t6_ready", 32'(tx_ready_o), 32'd1);
      lows = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (tx_o !== 1'b1) lows++;
      end
      check("t6_no_more_frames", 32'(lows), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
